// File: rtl/score_update_arbiter.sv
// Round-robin arbiter for lane hit judgements; scores one event per three cycles and
// tracks combo, multiplier and a saturating 32-bit total.
module score_update_arbiter #(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned PERFECT_PTS = 100,
  parameter int unsigned GOOD_PTS    = 50,
  parameter int unsigned COMBO_STEP  = 10,
  parameter int unsigned MAX_MULT    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [NUM_LANES-1:0]   lane_req,
  input  logic [2*NUM_LANES-1:0] lane_judge,
  output logic [NUM_LANES-1:0]   lane_ack,
  output logic [31:0]            score_total,
  output logic [15:0]            combo,
  output logic [2:0]             multiplier,
  output logic                   busy
);

  localparam int unsigned PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]    state_q;
  logic [PW-1:0] ptr_q;
  logic [1:0]    judge_q;
  logic [31:0]   pts_q;
  logic [31:0]   score_q;
  logic [15:0]   combo_q;
  logic [2:0]    mult_q;

  logic [PW-1:0] grant_idx;
  logic [PW-1:0] cand;
  logic [PW-1:0] ptr_next;
  logic          grant_found;
  logic          grant;
  logic [31:0]   base_pts;
  logic [31:0]   pts_calc;
  logic          hit;
  logic [32:0]   sum;
  logic [31:0]   score_next;
  logic [15:0]   combo_next;
  logic [15:0]   quot;
  logic [2:0]    mult_next;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      cand = PW'((int'(ptr_q) + i) % int'(NUM_LANES));
      if (!grant_found && lane_req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant    = (state_q == IDLE) && !clear && !reset && grant_found;
  assign lane_ack = grant ? (NUM_LANES'(1) << grant_idx) : '0;
  assign ptr_next = (grant_idx == PW'(NUM_LANES - 1)) ? '0 : grant_idx + PW'(1);

  always_comb begin
    case (judge_q)
      2'b01:   base_pts = 32'(GOOD_PTS);
      2'b10:   base_pts = 32'(PERFECT_PTS);
      default: base_pts = 32'd0;
    endcase
    pts_calc = base_pts * {29'd0, mult_q};
  end

  always_comb begin
    hit        = (judge_q == 2'b01) || (judge_q == 2'b10);
    sum        = {1'b0, score_q} + {1'b0, pts_q};
    score_next = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    if (!hit) begin
      combo_next = 16'd0;
    end else if (combo_q == 16'hFFFF) begin
      combo_next = 16'hFFFF;
    end else begin
      combo_next = combo_q + 16'd1;
    end
    quot      = combo_next / 16'(COMBO_STEP);
    mult_next = (quot >= 16'(MAX_MULT - 1)) ? 3'(MAX_MULT) : 3'(quot + 16'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      judge_q <= 2'b00;
      pts_q   <= 32'd0;
      score_q <= 32'd0;
      combo_q <= 16'd0;
      mult_q  <= 3'd1;
    end else if (clear) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      score_q <= 32'd0;
      combo_q <= 16'd0;
      mult_q  <= 3'd1;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            judge_q <= lane_judge[{grant_idx, 1'b0} +: 2];
            ptr_q   <= ptr_next;
            state_q <= CALC;
          end
        end
        CALC: begin
          pts_q   <= pts_calc;
          state_q <= COMMIT;
        end
        COMMIT: begin
          score_q <= score_next;
          combo_q <= combo_next;
          mult_q  <= mult_next;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign score_total = score_q;
  assign combo       = combo_q;
  assign multiplier  = mult_q;
  assign busy        = (state_q != IDLE);

endmodule
